// File: rtl/kn8_sum_accum.sv
// -----------------------------------------------------------------------------
// kn8_sum_accum
//
// Framed reduction stage behind the 8-bit prefix adder. Each accepted beat
// carries the adder result {in_co_i, in_sum_i} (0..510). The beat is
// zero-extended and summed into a wide accumulator. On the beat flagged with
// in_last_i, the frame total, the beat count and a sticky overflow flag are
// presented on a valid/ready output port. They stay there until the
// downstream handshake.
//
// Parameters:
//   ACC_W  accumulator / out_sum_o width   (>= 9)
//   CNT_W  beat counter / out_count_o width (>= 1)
//
// Ports:
//   clk_i        system clock, all state changes on the rising edge
//   rst_n_i      synchronous active-low reset, overrides everything
//   in_valid_i   upstream beat valid
//   in_ready_o   beat can be accepted this cycle (low while a result is held)
//   in_co_i      adder carry-out (beat bit 8)
//   in_sum_i     adder sum, in_sum_i[7] is the MSB
//   in_last_i    final beat of the frame
//   out_valid_o  frame result available
//   out_ready_i  downstream accepts the result
//   out_sum_o    frame total (wrapped or saturated on overflow)
//   out_count_o  beats in the frame (saturating)
//   out_ovf_o    sticky frame overflow flag
//
// Build option:
//   KN8_SUM_ACCUM_SATURATE_EN  when defined, an overflowing add clamps the
//                              accumulator to all ones. When undefined, it
//                              wraps modulo 2^ACC_W. Either way out_ovf_o is set.
// -----------------------------------------------------------------------------
module kn8_sum_accum #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             in_co_i,
    input  logic [7:0]       in_sum_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_sum_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_ovf_o
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    // State registers and their next-state values
    logic [1:0]       state_q,     state_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q,  in_ready_d;

    // Datapath helpers
    logic [ACC_W:0]   beat_ext_s;   // beat value zero-extended to ACC_W+1
    logic [ACC_W:0]   sum_ext_s;    // acc + beat including the carry out of ACC_W-1
    logic             accept_s;
    logic             add_ovf_s;
    logic             cnt_sat_s;
    logic [ACC_W-1:0] acc_add_s;    // accumulator after an overflow-aware add

    // Sum of accumulator and beat, one bit wider so the carry is visible.
    function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] acc,
                                               input logic [ACC_W:0]   beat);
        add_ext = {1'b0, acc} + beat;
    endfunction

    // Zero-extend the 9-bit adder result without a zero-width replication.
    always_comb begin
        beat_ext_s      = '0;
        beat_ext_s[8:0] = {in_co_i, in_sum_i};
    end

    // Accumulate arithmetic, overflow detection and counter saturation.
    always_comb begin
        sum_ext_s = add_ext(acc_q, beat_ext_s);
        add_ovf_s = sum_ext_s[ACC_W];
        cnt_sat_s = (cnt_q == CNT_MAX);
`ifdef KN8_SUM_ACCUM_SATURATE_EN
        // Once clamped, later beats either add 0 (stays at max) or overflow
        // again (re-clamped), so the value holds for the rest of the frame.
        if (add_ovf_s) begin
            acc_add_s = ACC_MAX;
        end else begin
            acc_add_s = sum_ext_s[ACC_W-1:0];
        end
`else
        acc_add_s = sum_ext_s[ACC_W-1:0];
`endif
    end

    // The accept handshake uses the registered ready, so HOLD blocks input.
    always_comb begin
        accept_s = in_valid_i & in_ready_q;
    end

    // Next-state logic for the frame FSM and the accumulator datapath.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // First beat opens the frame and clears the previous flags.
                    acc_d = beat_ext_s[ACC_W-1:0];
                    cnt_d = CNT_ONE;
                    ovf_d = 1'b0;
                    if (in_last_i) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCUM: begin
                if (accept_s) begin
                    acc_d = acc_add_s;
                    if (cnt_sat_s) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    ovf_d = ovf_q | add_ovf_s | cnt_sat_s;
                    if (in_last_i) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end

            ST_HOLD: begin
                // Input is blocked here. Only the output handshake can move us.
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Handshake flags are decoded from the next state so that they are flops.
    always_comb begin
        out_valid_d = (state_d == ST_HOLD);
        in_ready_d  = (state_d != ST_HOLD);
    end

    // Sequential state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Outputs come straight from registers. acc/cnt/ovf do not change while
    // HOLD is active, so the result is stable until the handshake.
    always_comb begin
        in_ready_o  = in_ready_q;
        out_valid_o = out_valid_q;
        out_sum_o   = acc_q;
        out_count_o = cnt_q;
        out_ovf_o   = ovf_q;
    end

endmodule

// File: doc/kn8_sum_accum.md
Name: kn8_sum_accum

Overview:
Downstream consumer of the 8-bit prefix adder stage. Accepts the adder's 9-bit result (carry-out plus 8-bit sum) one element per accepted beat, and accumulates a framed stream of results into a wide accumulator. At frame end it presents the total, the element count and an overflow flag on a valid/ready output port. It is the registered boundary that turns the purely combinational adder into a usable reduction datapath.

Parameters:
ACC_W, 16, accumulator and out_sum width in bits; legal range >= 9.
CNT_W, 8, element counter and out_count width in bits; legal range >= 1.

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
rst_n  input  1  synchronous reset, active low.
in_valid  input  1  upstream result beat valid.
in_ready  output  1  block can accept a beat this cycle.
in_co  input  1  adder carry-out, the adder's most-significant output.
in_sum  input  8  adder sum; in_sum[7] is the MSB. Integration maps the adder's MSB-first sum outputs onto in_sum[7] down to in_sum[0].
in_last  input  1  marks the final beat of a frame.
out_valid  output  1  frame result available.
out_ready  input  1  downstream accepts the result.
out_sum  output  ACC_W  frame total.
out_count  output  CNT_W  number of beats in the frame.
out_ovf  output  1  sticky frame overflow flag.

Behaviour:
- Reset: rst_n is sampled low on a clk edge. state=IDLE; acc, cnt, ovf cleared to 0; out_valid=0, out_sum=0, out_count=0, out_ovf=0. Reset is synchronous and active-low, and it overrides everything, including mid-frame and HOLD.
- Beat value: v = {in_co, in_sum}, zero-extended to ACC_W. Range is 0..510.
- Accept: a beat is accepted when in_valid & in_ready at a clk edge.
- in_ready: 1 in IDLE and ACCUM, 0 in HOLD.
- States:
  - IDLE: no frame open. On accept: acc=v, cnt=1, ovf=0.
    - If in_last: go to HOLD.
    - Else: go to ACCUM.
  - ACCUM: frame open. On accept: acc=acc+v, cnt=cnt+1, ovf updated (see below).
    - If in_last: go to HOLD.
    - Else: stay in ACCUM.
    - No accept: hold all state.
  - HOLD: out_valid=1. out_sum, out_count and out_ovf are driven from acc, cnt and ovf, and are stable until the handshake. On out_valid & out_ready: go to IDLE; out_valid=0 on the next cycle.
- Latency:
  - A last beat accepted at edge N gives out_valid=1 after edge N (registered). The earliest handshake is at edge N+1.
  - The next frame's first beat is accepted at the earliest at edge N+2, because HOLD blocks input.
  - Peak throughput: one frame per (beats+1) cycles.
- Arithmetic: the sum is ACC_W+1 bits wide. If the carry out of bit ACC_W-1 is set, ovf=1 and acc keeps the low ACC_W bits (wrap).
- Counter: cnt saturates at 2^CNT_W-1. An accept while cnt is saturated sets ovf=1.
- ovf is sticky within the frame and is cleared at the first beat of the next frame.
- in_valid during HOLD is ignored and has no side effect. in_co, in_sum and in_last are don't-care when in_valid=0.
- out_valid never drops without a handshake, except on reset.
- Simultaneous in_valid and out_ready in HOLD: only the output handshake occurs.

Optional Feature:
Macro: KN8_SUM_ACCUM_SATURATE_EN.
- Defined: when an add overflows, acc=2^ACC_W-1 and stays there for the rest of the frame; ovf=1.
- Undefined: wrap-around as described in Behaviour; ovf=1.
- Counter behaviour is identical in both builds.

Test Plan:
1. Single-beat frame: in_co=1, in_sum=0xFF, in_last=1, out_ready=1 -> out_valid one cycle later; out_sum=0x01FF, out_count=1, out_ovf=0; in_ready=0 for exactly one cycle.
2. Three-beat frame: {0,0x10}, {0,0xFF}, {1,0xFE} with last on the third beat -> out_sum=0x030D, out_count=3, out_ovf=0. Insert an in_valid gap between beats 1 and 2 -> same result.
3. Overflow, ACC_W=16: 130 beats of {1,0xFE} (510 each, total 66300):
   - Default build -> out_sum=0x02FC, out_ovf=1, out_count=130.
   - With KN8_SUM_ACCUM_SATURATE_EN -> out_sum=0xFFFF, out_ovf=1.
4. Backpressure: result in HOLD, out_ready=0 for 5 cycles while in_valid=1 with {1,0x01} -> out_valid, out_sum and out_count stable; in_ready=0; no beat absorbed. Then out_ready=1 -> handshake; the next frame starts clean.
5. Reset mid-frame: after 2 accepted beats, rst_n=0 for one cycle -> all outputs 0, state IDLE. Then a single-beat frame {0,0x05} last -> out_sum=0x0005, out_count=1.
6. Count saturation, CNT_W=4: 17 beats of {0,0x01} -> out_count=15, out_sum=0x0011, out_ovf=1.
